// File: rtl/mux8_1_reg.sv
// 8-to-1 data selector with a combinational output and an enable-loaded registered copy.
// Optional load-change pulse output chg is built when MUX8_1_CHG_DET_EN is defined.
module mux8_1_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [2:0]       sel_q
`ifdef MUX8_1_CHG_DET_EN
  ,
  output logic             chg
`endif
);

  // All eight select codes map to a port, so indexing needs no fallback.
  logic [7:0][WIDTH-1:0] d_arr;

  assign d_arr = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign y     = d_arr[s];

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= 3'd0;
    end else if (en) begin
      y_q   <= y;
      sel_q <= s;
    end
  end

`ifdef MUX8_1_CHG_DET_EN
  // Compare against the value being replaced, so chg is a single-cycle pulse per differing load.
  always_ff @(posedge clk) begin
    if (rst)     chg <= 1'b0;
    else if (en) chg <= (y != y_q);
    else         chg <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mux8_1_reg.sv
// Directed self-checking bench for mux8_1_reg at WIDTH=1 and WIDTH=8.
// The chg checks run only when MUX8_1_CHG_DET_EN is defined.
module tb_mux8_1_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic [7:0] dv1;
  logic [2:0] s1;
  logic       en1;
  logic       y1, yq1;
  logic [2:0] selq1;
  // WIDTH=8 instance
  logic [7:0][7:0] dv8;
  logic [2:0] s8;
  logic       en8;
  logic [7:0] y8, yq8;
  logic [2:0] selq8;
`ifdef MUX8_1_CHG_DET_EN
  logic       chg1, chg8;
`endif

  mux8_1_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .s(s1),
    .d0(dv1[0]), .d1(dv1[1]), .d2(dv1[2]), .d3(dv1[3]),
    .d4(dv1[4]), .d5(dv1[5]), .d6(dv1[6]), .d7(dv1[7]),
    .en(en1), .y(y1), .y_q(yq1), .sel_q(selq1)
`ifdef MUX8_1_CHG_DET_EN
    , .chg(chg1)
`endif
  );

  mux8_1_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .s(s8),
    .d0(dv8[0]), .d1(dv8[1]), .d2(dv8[2]), .d3(dv8[3]),
    .d4(dv8[4]), .d5(dv8[5]), .d6(dv8[6]), .d7(dv8[7]),
    .en(en8), .y(y8), .y_q(yq8), .sel_q(selq8)
`ifdef MUX8_1_CHG_DET_EN
    , .chg(chg8)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat_exp [8] = '{1, 0, 1, 0, 0, 1, 1, 0};
  // Hold-phase stimulus: {dv1, s1} and the expected y per step.
  logic [7:0] hold_d [4] = '{8'h00, 8'hFF, 8'h40, 8'hBF};
  logic [2:0] hold_s [4] = '{3'd2, 3'd5, 3'd6, 3'd6};
  logic       hold_y [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; en1 = 1'b0; en8 = 1'b0;
    dv1 = '0; s1 = '0; dv8 = '0; s8 = '0;
    tick();
    chk("rst_yq1",   yq1,   0);
    chk("rst_selq1", selq1, 0);
    chk("rst_yq8",   yq8,   0);
    chk("rst_selq8", selq8, 0);
    rst = 1'b0;

    // Exhaustive combinational sweep at WIDTH=1.
    for (int v = 0; v < 2048; v++) begin
      {dv1, s1} = v[10:0];
      #1;
      chk("sweep_y", y1, (dv1 >> s1) & 8'h01);
    end

    // Fixed pattern d0..d7 = 1,0,1,0,0,1,1,0 (d0 in bit 0).
    dv1 = 8'b0110_0101;
    for (int i = 0; i < 8; i++) begin
      s1 = 3'(i);
      #1;
      chk("pat_y", y1, pat_exp[i]);
    end

    // Load a nonzero value so the following reset is observable.
    en1 = 1'b1; s1 = 3'd7; dv1 = 8'h80;
    tick();
    chk("pre_yq1",   yq1,   1);
    chk("pre_selq1", selq1, 7);

    // Reset wins over en.
    rst = 1'b1; s1 = 3'd3; dv1 = 8'h08;
    tick();
    chk("midrst_yq1",   yq1,   0);
    chk("midrst_selq1", selq1, 0);
    rst = 1'b0;
    tick();
    chk("load_yq1",   yq1,   1);
    chk("load_selq1", selq1, 3);

    // en=0: y tracks, registers hold.
    en1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dv1 = hold_d[i]; s1 = hold_s[i];
      #1;
      chk("hold_y", y1, hold_y[i]);
      tick();
      chk("hold_yq1",   yq1,   1);
      chk("hold_selq1", selq1, 3);
    end

    // WIDTH=8 path.
    dv8 = '0; dv8[5] = 8'hA5; s8 = 3'd5; en8 = 1'b1;
    #1;
    chk("w8_y_a5", y8, 8'hA5);
    tick();
    chk("w8_yq_a5",  yq8,   8'hA5);
    chk("w8_sel_5",  selq8, 5);
    s8 = 3'd0;
    #1;
    chk("w8_y_00", y8, 8'h00);
    tick();
    chk("w8_yq_00",  yq8,   8'h00);
    chk("w8_sel_0",  selq8, 0);
    en8 = 1'b0;

`ifdef MUX8_1_CHG_DET_EN
    rst = 1'b1;
    tick();
    chk("chg_rst", chg1, 0);
    rst = 1'b0; en1 = 1'b1; s1 = 3'd0;
    dv1 = 8'h00; tick(); chk("chg_load0",  chg1, 0);
    dv1 = 8'h01; tick(); chk("chg_load1",  chg1, 1);
    tick();              chk("chg_load1b", chg1, 0);
    dv1 = 8'h00; tick(); chk("chg_load0b", chg1, 1);
    rst = 1'b1;  tick(); chk("chg_rstpulse", chg1, 0);
    rst = 1'b0; dv1 = 8'h01; tick(); chk("chg_again", chg1, 1);
    en1 = 1'b0; tick(); chk("chg_en0", chg1, 0);
    chk("chg8_idle", chg8, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
